// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: shared types, constants and op helpers for the RV32M mul/div unit
package ex_muldiv_unit_pkg;
   localparam int XLEN = 32;
   localparam int CNT_W = 5;
   localparam logic [6:0] OPCODE_OP = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_e;
   function automatic logic is_div(muldiv_op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction
   function automatic logic is_rem(muldiv_op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction
endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: ID/EX request and EX/MEM result bundle of the mul/div unit
interface ex_muldiv_unit_if;
   import ex_muldiv_unit_pkg::*;
   logic valid_i;
   logic [31:0] instruction_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic [4:0] rd_addr_i;
   logic flush_i;
   logic stall_o;
   logic busy_o;
   logic done_o;
   logic [XLEN-1:0] result_o;
   logic [4:0] rd_addr_o;
   modport master (
      output valid_i, instruction_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
      input stall_o, busy_o, done_o, result_o, rd_addr_o
   );
   modport slave (
      input valid_i, instruction_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
      output stall_o, busy_o, done_o, result_o, rd_addr_o
   );
endinterface

// File: rtl/ex_muldiv_unit_datapath.sv
// ex_muldiv_unit_datapath: radix-2 shift-add/shift-subtract engine with sign fixup and special cases
module ex_muldiv_unit_datapath
   import ex_muldiv_unit_pkg::*;
(
   input logic clk,
   input logic rst,
   input logic start_i,
   input logic step_i,
   input muldiv_op_e op_i,
   input logic [XLEN-1:0] rs1_i,
   input logic [XLEN-1:0] rs2_i,
   output logic special_o,
   output logic [XLEN-1:0] special_res_o,
   output logic [XLEN-1:0] result_o
);
   muldiv_op_e op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic neg_p_q, neg_p_d, neg_r_q, neg_r_d;
   logic s1, s2, sdiv, ge;
   logic [XLEN-1:0] mag1, mag2, dif, quo, rem;
   logic [XLEN:0] sum, hi;
   logic [2*XLEN-1:0] nxt, prod;
   // operand signs, magnitudes and the divide-by-zero / overflow shortcut
   always_comb begin
      sdiv = op_i inside {OP_DIV, OP_REM};
      s1 = rs1_i[XLEN-1] & (op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
      s2 = rs2_i[XLEN-1] & (op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
      mag1 = s1 ? -rs1_i : rs1_i;
      mag2 = s2 ? -rs2_i : rs2_i;
      special_o = is_div(op_i) & ((rs2_i == '0) | (sdiv & rs1_i == {1'b1, {(XLEN-1){1'b0}}} & rs2_i == '1));
      special_res_o = rs2_i == '0 ? (is_rem(op_i) ? rs1_i : '1) : (is_rem(op_i) ? '0 : rs1_i);
   end
   // one iteration step; the result is formed from the post-step value so it is ready on the last step
   always_comb begin
      sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
      hi = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      ge = hi >= {1'b0, a_q};
      dif = hi[XLEN-1:0] - a_q;
      nxt = is_div(op_q) ? {ge ? dif : hi[XLEN-1:0], acc_q[XLEN-2:0], ge} : {sum, acc_q[XLEN-1:1]};
      prod = neg_p_q ? -nxt : nxt;
      quo = neg_p_q ? -nxt[XLEN-1:0] : nxt[XLEN-1:0];
      rem = neg_r_q ? -nxt[2*XLEN-1:XLEN] : nxt[2*XLEN-1:XLEN];
      result_o = op_q == OP_MUL ? prod[XLEN-1:0] : !is_div(op_q) ? prod[2*XLEN-1:XLEN] : is_rem(op_q) ? rem : quo;
      op_d = start_i ? op_i : op_q;
      a_d = start_i ? (is_div(op_i) ? mag2 : mag1) : a_q;
      acc_d = start_i ? {{XLEN{1'b0}}, is_div(op_i) ? mag1 : mag2} : step_i ? nxt : acc_q;
      neg_p_d = start_i ? s1 ^ s2 : neg_p_q;
      neg_r_d = start_i ? s1 : neg_r_q;
   end
   // operand, accumulator and sign-flag registers
   always_ff @(posedge clk)
      if (rst) begin
         op_q <= OP_MUL;
         a_q <= '0;
         acc_q <= '0;
         neg_p_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else begin
         op_q <= op_d;
         a_q <= a_d;
         acc_q <= acc_d;
         neg_p_q <= neg_p_d;
         neg_r_q <= neg_r_d;
      end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit with pipeline stall control
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
(
   input logic clk,
   input logic rst,
   ex_muldiv_unit_if.slave bus
);
   muldiv_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic done_q, done_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0] rd_q, rd_d, rd_lat_q, rd_lat_d;
   logic req, start, step, special, unused_bits;
   logic [XLEN-1:0] special_res, dp_result;
   muldiv_op_e op;
   assign req = bus.valid_i & bus.instruction_i[6:0] == OPCODE_OP & bus.instruction_i[31:25] == FUNCT7_MULDIV;
   assign op = muldiv_op_e'(bus.instruction_i[14:12]);
   assign start = !bus.flush_i & state_q == IDLE & req & !special;
   assign step = state_q == CALC;
   assign unused_bits = ^{bus.instruction_i[24:15], bus.instruction_i[11:7]};
   assign bus.stall_o = !bus.flush_i & ((state_q == IDLE & req) | state_q == CALC);
   assign bus.busy_o = state_q != IDLE;
   assign bus.done_o = done_q;
   assign bus.result_o = result_q;
   assign bus.rd_addr_o = rd_q;
   ex_muldiv_unit_datapath u_dp (
      .clk(clk),
      .rst(rst),
      .start_i(start),
      .step_i(step),
      .op_i(op),
      .rs1_i(bus.rs1_data_i),
      .rs2_i(bus.rs2_data_i),
      .special_o(special),
      .special_res_o(special_res),
      .result_o(dp_result)
   );
   // next state: accept in IDLE, iterate 32 steps in CALC, one-cycle DONE; flush squashes anything
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      done_d = 1'b0;
      result_d = result_q;
      rd_d = rd_q;
      rd_lat_d = rd_lat_q;
      if (bus.flush_i)
         state_d = IDLE;
      else
         case (state_q)
            IDLE: if (req) begin
               state_d = special ? DONE : CALC;
               done_d = special;
               result_d = special ? special_res : result_q;
               rd_d = special ? bus.rd_addr_i : rd_q;
               rd_lat_d = bus.rd_addr_i;
               cnt_d = '0;
            end
            CALC: begin
               cnt_d = cnt_q + 1'b1;
               state_d = &cnt_q ? DONE : CALC;
               done_d = &cnt_q;
               result_d = &cnt_q ? dp_result : result_q;
               rd_d = &cnt_q ? rd_lat_q : rd_q;
            end
            default: state_d = IDLE;
         endcase
   end
   // FSM, counter and registered outputs
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         done_q <= 1'b0;
         result_q <= '0;
         rd_q <= '0;
         rd_lat_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         done_q <= done_d;
         result_q <= result_d;
         rd_q <= rd_d;
         rd_lat_q <= rd_lat_d;
      end
endmodule
